// File: rtl/addr_err_req_if.sv
// Bus bundle between the address-check front end and the CP0 bad-address logic.
interface addr_err_req_if #(parameter int NEST_DEPTH = 2) ();
  localparam int LW = $clog2(NEST_DEPTH + 1);

  logic          if_valid;
  logic [31:0]   if_pc;
  logic          mem_valid;
  logic          mem_wr;
  logic [1:0]    mem_size;
  logic [31:0]   mem_addr;
  logic          kernel_mode;
  logic          exc_ack;
  logic          eret;
  logic          exc_req;
  logic [4:0]    exc_code;
  logic          addr_err;
  logic [31:0]   badvaddr_p;
  logic          r_p;
  logic          r_h;
  logic [LW-1:0] nest_level;
  logic          nest_ovf;

  modport master (
    output if_valid, if_pc, mem_valid, mem_wr, mem_size, mem_addr, kernel_mode, exc_ack, eret,
    input  exc_req, exc_code, addr_err, badvaddr_p, r_p, r_h, nest_level, nest_ovf
  );

  modport slave (
    input  if_valid, if_pc, mem_valid, mem_wr, mem_size, mem_addr, kernel_mode, exc_ack, eret,
    output exc_req, exc_code, addr_err, badvaddr_p, r_p, r_h, nest_level, nest_ovf
  );
endinterface

// File: rtl/addr_err_req_unit.sv
// Address-error request producer: flags misaligned/privileged addresses and tracks nesting.
// state | meaning:  IDLE | watching for faults and eret;  REQ | request raised, waiting for exc_ack
module addr_err_req_unit #(
  parameter int NEST_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  addr_err_req_if.slave bus
);
  localparam int LW = $clog2(NEST_DEPTH + 1);
  localparam logic [LW-1:0] NEST_MAX = LW'(NEST_DEPTH);
  localparam logic [4:0] ADEL = 5'd4;
  localparam logic [4:0] ADES = 5'd5;

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_q, state_n;
  logic [4:0]    code_q, code_n;
  logic [31:0]   bad_q, bad_n;
  logic [LW-1:0] nest_q, nest_n;
  logic          ovf_q, ovf_n;
  logic          addr_err_q, addr_err_n;
  logic          r_p_q, r_p_n;
  logic          r_h_q, r_h_n;
  logic          mem_mis, fetch_fault, mem_fault;

  always_comb begin
    unique case (bus.mem_size)
      2'b00:   mem_mis = 1'b0;
      2'b01:   mem_mis = bus.mem_addr[0];
      default: mem_mis = |bus.mem_addr[1:0];
    endcase
    fetch_fault = bus.if_valid & ((|bus.if_pc[1:0]) | (~bus.kernel_mode & bus.if_pc[31]));
    mem_fault   = bus.mem_valid & (mem_mis | (~bus.kernel_mode & bus.mem_addr[31]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= 5'd0;
      bad_q      <= 32'h0;
      nest_q     <= '0;
      ovf_q      <= 1'b0;
      addr_err_q <= 1'b0;
      r_p_q      <= 1'b0;
      r_h_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      code_q     <= code_n;
      bad_q      <= bad_n;
      nest_q     <= nest_n;
      ovf_q      <= ovf_n;
      addr_err_q <= addr_err_n;
      r_p_q      <= r_p_n;
      r_h_q      <= r_h_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    code_n     = code_q;
    bad_n      = bad_q;
    nest_n     = nest_q;
    ovf_n      = ovf_q;
    addr_err_n = 1'b0;
    r_p_n      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The load/store belongs to the older instruction, so it outranks the fetch.
        if (mem_fault) begin
          state_n    = REQ;
          addr_err_n = 1'b1;
          bad_n      = bus.mem_addr;
          code_n     = bus.mem_wr ? ADES : ADEL;
        end else if (fetch_fault) begin
          state_n    = REQ;
          addr_err_n = 1'b1;
          bad_n      = bus.if_pc;
          code_n     = ADEL;
        end else if (bus.eret && (nest_q != '0)) begin
          nest_n = nest_q - LW'(1);
          r_p_n  = 1'b1;
        end
      end
      REQ: begin
        if (bus.exc_ack) begin
          state_n = IDLE;
          if (nest_q == NEST_MAX) ovf_n  = 1'b1;
          else                    nest_n = nest_q + LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    r_h_n = (nest_n != '0) & ~addr_err_n & ~r_p_n;
  end

  assign bus.exc_req    = (state_q == REQ);
  assign bus.exc_code   = code_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.badvaddr_p = bad_q;
  assign bus.r_p        = r_p_q;
  assign bus.r_h        = r_h_q;
  assign bus.nest_level = nest_q;
  assign bus.nest_ovf   = ovf_q;
endmodule

// File: tb/tb_addr_err_req_unit.sv
// Scoreboard bench: driver predicts each cycle's outputs from the address-error rules, monitor compares.
module tb_addr_err_req_unit;
  localparam int DEPTH = 2;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [31:0] pc;
    bit          mv;
    bit          mw;
    logic [1:0]  sz;
    logic [31:0] ma;
    bit          km;
    bit          ack;
    bit          er;
  } stim_t;

  typedef struct {
    bit          exc_req;
    logic [4:0]  code;
    logic [31:0] bad;
    bit          addr_err;
    bit          r_p;
    bit          r_h;
    int          level;
    bit          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addr_err_req_if #(.NEST_DEPTH(DEPTH)) bus ();
  addr_err_req_unit #(.NEST_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state
  bit          m_pending;
  logic [4:0]  m_code;
  logic [31:0] m_bad;
  int          m_level;
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
    int bytes;
    bytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    return (a % bytes) != 0;
  endfunction

  function automatic bit user_bad(input logic [31:0] a, input bit km);
    return !km && (a >= 32'h8000_0000);
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{rst: 0, iv: 0, pc: 32'h0, mv: 0, mw: 0, sz: 2'b10, ma: 32'h0, km: 1, ack: 0, er: 0};
    return s;
  endfunction

  // Drive one cycle and predict what the outputs look like after the next rising edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit   mf, ff;
    rst             = s.rst;
    bus.if_valid    = s.iv;
    bus.if_pc       = s.pc;
    bus.mem_valid   = s.mv;
    bus.mem_wr      = s.mw;
    bus.mem_size    = s.sz;
    bus.mem_addr    = s.ma;
    bus.kernel_mode = s.km;
    bus.exc_ack     = s.ack;
    bus.eret        = s.er;
    e.addr_err = 0;
    e.r_p      = 0;
    if (s.rst) begin
      m_pending = 0; m_code = 5'd0; m_bad = 32'h0; m_level = 0; m_ovf = 0;
    end else if (!m_pending) begin
      mf = s.mv && (misaligned(s.ma, s.sz) || user_bad(s.ma, s.km));
      ff = s.iv && (misaligned(s.pc, 2'b10) || user_bad(s.pc, s.km));
      if (mf) begin
        m_pending = 1; e.addr_err = 1; m_bad = s.ma; m_code = s.mw ? 5'd5 : 5'd4;
      end else if (ff) begin
        m_pending = 1; e.addr_err = 1; m_bad = s.pc; m_code = 5'd4;
      end else if (s.er && m_level > 0) begin
        m_level--; e.r_p = 1;
      end
    end else if (s.ack) begin
      m_pending = 0;
      if (m_level == DEPTH) m_ovf = 1;
      else m_level++;
    end
    e.exc_req = m_pending;
    e.code    = m_code;
    e.bad     = m_bad;
    e.level   = m_level;
    e.ovf     = m_ovf;
    e.r_h     = (m_level > 0) && !e.addr_err && !e.r_p;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("exc_req", 32'(bus.exc_req), 32'(e.exc_req));
        if (e.exc_req) chk("exc_code", 32'(bus.exc_code), 32'(e.code));
        chk("badvaddr_p", bus.badvaddr_p, e.bad);
        chk("addr_err", 32'(bus.addr_err), 32'(e.addr_err));
        chk("r_p", 32'(bus.r_p), 32'(e.r_p));
        chk("r_h", 32'(bus.r_h), 32'(e.r_h));
        chk("nest_level", 32'(bus.nest_level), 32'(e.level));
        chk("nest_ovf", 32'(bus.nest_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle_s();
    s.rst = 1;
    step(s); step(s);

    // Misaligned word load, held across idle cycles, then acked.
    s = idle_s(); s.mv = 1; s.sz = 2'b10; s.ma = 32'h0000_1002; step(s);
    s = idle_s(); step(s); step(s);
    s.ack = 1; step(s);
    s = idle_s(); step(s);

    // Fetch and half store fault together: store wins.
    s = idle_s(); s.iv = 1; s.pc = 32'h0040_0001; s.mv = 1; s.mw = 1; s.sz = 2'b01; s.ma = 32'h0000_2001;
    step(s);
    s = idle_s(); s.ack = 1; step(s);

    // User fetch of kernel space; a new fault during REQ is ignored; third ack overflows.
    s = idle_s(); s.km = 0; s.iv = 1; s.pc = 32'h8000_0000; step(s);
    s = idle_s(); s.mv = 1; s.ma = 32'h0000_0003; step(s);
    s = idle_s(); step(s);
    s.ack = 1; s.er = 1; step(s);

    // Three erets: two restores, third ignored.
    for (int i = 0; i < 3; i++) begin
      s = idle_s(); s.er = 1; step(s);
      s = idle_s(); step(s);
    end

    // ack+eret at level 1, then reset while a request is pending.
    s = idle_s(); s.iv = 1; s.pc = 32'h0000_0102; step(s);
    s = idle_s(); s.ack = 1; step(s);
    s = idle_s(); s.iv = 1; s.pc = 32'h0000_0202; step(s);
    s = idle_s(); s.ack = 1; s.er = 1; step(s);
    s = idle_s(); s.mv = 1; s.sz = 2'b11; s.ma = 32'h0000_0006; s.er = 1; step(s);
    s = idle_s(); s.rst = 1; step(s);
    s = idle_s(); step(s);

    for (int i = 0; i < 1500; i++) begin
      s = idle_s();
      s.rst = ($urandom_range(0, 99) == 0);
      s.km  = ($urandom_range(0, 3) != 0);
      s.iv  = ($urandom_range(0, 1) == 0);
      s.pc  = $urandom & (($urandom_range(0, 2) != 0) ? 32'hffff_fffc : 32'hffff_ffff);
      s.mv  = ($urandom_range(0, 2) == 0);
      s.mw  = $urandom_range(0, 1);
      s.sz  = 2'($urandom_range(0, 3));
      s.ma  = $urandom & (($urandom_range(0, 1) != 0) ? 32'hffff_fffc : 32'hffff_ffff);
      s.ack = ($urandom_range(0, 2) == 0);
      s.er  = ($urandom_range(0, 3) == 0);
      step(s);
    end

    s = idle_s(); step(s); step(s);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
